// File: rtl/tc_io_pad_arbiter.sv
// Round-robin arbiter sharing one bidirectional IO pad among NumReq requesters.
// Grant is combinational in ACTIVE; read data returns one cycle after the transfer.
// A requester is stalled (gnt low) whenever it does not own the pad in the matching direction.
module tc_io_pad_arbiter #(
    parameter int NumReq     = 2,
    parameter int TurnCycles = 2,
    parameter int MaxBurst   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_i,
    input  logic [NumReq-1:0]         we_i,
    input  logic [NumReq-1:0]         wdata_i,
    output logic [NumReq-1:0]         gnt_o,
    output logic                      rdata_o,
    output logic                      rvalid_o,
    output logic [$clog2(NumReq)-1:0] rid_o,
    input  logic [3:0]                cfg_drv_i,
    input  logic [1:0]                cfg_pull_i,
    output logic                      pad_data_o,
    input  logic                      pad_data_i,
    output logic                      pad_oe_no,
    output logic [3:0]                pad_drv_o,
    output logic                      pad_pu_o,
    output logic                      pad_pd_o
);
    localparam int IdxW = $clog2(NumReq);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TURN   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] last_q, last_d;
    logic            dir_q, dir_d;
    logic [7:0]      burst_q, burst_d;
    logic [3:0]      turn_q, turn_d;
    logic            rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic [IdxW-1:0] rid_q, rid_d;
    logic [3:0]      drv_q, drv_d;
    logic            pu_q, pu_d;
    logic            pd_q, pd_d;

    logic            found;
    logic [IdxW-1:0] win;
    logic            xfer;
    logic [7:0]      burst_inc;
    int              cand;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand = (int'(last_q) + 1 + i) % NumReq;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = IdxW'(cand);
            end
        end
    end

    assign burst_inc = burst_q + 8'd1;

    // Next-state, grant and pad-drive logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        dir_d      = dir_q;
        burst_d    = burst_q;
        turn_d     = turn_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        rid_d      = rid_q;
        drv_d      = drv_q;
        pu_d       = pu_q;
        pd_d       = pd_q;
        xfer       = 1'b0;
        gnt_o      = '0;
        pad_oe_no  = 1'b1;
        pad_data_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Pad strength/pulls only change while nobody owns the pad;
                // a conflicting pull-up + pull-down request disables both.
                drv_d = cfg_drv_i;
                pu_d  = (cfg_pull_i == 2'b01);
                pd_d  = (cfg_pull_i == 2'b10);
                if (found) begin
                    owner_d = win;
                    dir_d   = we_i[win];
                    burst_d = 8'd0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                xfer           = req_i[owner_q] && (we_i[owner_q] == dir_q);
                gnt_o[owner_q] = xfer;
                if (dir_q) begin
                    pad_oe_no  = 1'b0;
                    pad_data_o = wdata_i[owner_q];
                end
                if (xfer) begin
                    burst_d = burst_inc;
                    if (!dir_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = pad_data_i;
                        rid_d    = owner_q;
                    end
                end
                // Leave on a dropped/flipped request or when the burst quota is used up.
                if (!xfer || (burst_inc == 8'(MaxBurst))) begin
                    last_d = owner_q;
                    if (dir_q) begin
                        state_d = TURN;
                        turn_d  = 4'(TurnCycles - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                if (turn_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset releases the pad immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            last_q   <= IdxW'(NumReq - 1);
            dir_q    <= 1'b0;
            burst_q  <= 8'd0;
            turn_q   <= 4'd0;
            rdata_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            drv_q    <= 4'd0;
            pu_q     <= 1'b0;
            pd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            dir_q    <= dir_d;
            burst_q  <= burst_d;
            turn_q   <= turn_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            drv_q    <= drv_d;
            pu_q     <= pu_d;
            pd_q     <= pd_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = rid_q;
    assign pad_drv_o = drv_q;
    assign pad_pu_o  = pu_q;
    assign pad_pd_o  = pd_q;

endmodule

// File: tb/tb_tc_io_pad_arbiter.sv
// Directed bench for tc_io_pad_arbiter (NumReq=2, TurnCycles=2, MaxBurst=4).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
// Each scenario task carries its own hand-computed expectations.
module tb_tc_io_pad_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0, we = '0, wdata = '0;
    logic [1:0] gnt;
    logic       rdata, rvalid, rid;
    logic [3:0] cfg_drv = 4'hF;
    logic [1:0] cfg_pull = 2'b01;
    logic       pad_data, pad_in = 1'b0, pad_oe_n;
    logic [3:0] pad_drv;
    logic       pad_pu, pad_pd;
    int         checks = 0;
    int         errors = 0;

    tc_io_pad_arbiter #(.NumReq(2), .TurnCycles(2), .MaxBurst(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .wdata_i(wdata),
        .gnt_o(gnt), .rdata_o(rdata), .rvalid_o(rvalid), .rid_o(rid),
        .cfg_drv_i(cfg_drv), .cfg_pull_i(cfg_pull), .pad_data_o(pad_data),
        .pad_data_i(pad_in), .pad_oe_no(pad_oe_n), .pad_drv_o(pad_drv),
        .pad_pu_o(pad_pu), .pad_pd_o(pad_pd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(); rst_n = 1'b0; req = '0; we = '0; wdata = '0;
        step(); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", gnt); end
        checks++; if (pad_oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe got %b want 1", pad_oe_n); end
        checks++; if (pad_data !== 1'b0) begin errors++; $display("FAIL rst_data got %b want 0", pad_data); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
        checks++; if (rdata !== 1'b0) begin errors++; $display("FAIL rst_rdata got %b want 0", rdata); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL rst_rid got %b want 0", rid); end
        checks++; if (pad_drv !== 4'h0) begin errors++; $display("FAIL rst_drv got %h want 0", pad_drv); end
        checks++; if (pad_pu !== 1'b0) begin errors++; $display("FAIL rst_pu got %b want 0", pad_pu); end
        checks++; if (pad_pd !== 1'b0) begin errors++; $display("FAIL rst_pd got %b want 0", pad_pd); end
        step(); rst_n = 1'b1;
    endtask

    task automatic test_write();
        // IDLE cycle: request seen, no grant yet.
        step(); req = 2'b01; we = 2'b01; wdata = 2'b01; cfg_drv = 4'h5; cfg_pull = 2'b01;
        mid();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL wr_idle_gnt got %b want 00", gnt); end
        checks++; if (pad_oe_n !== 1'b1) begin errors++; $display("FAIL wr_idle_oe got %b want 1", pad_oe_n); end
        // Three granted write cycles; cfg changes mid-burst must not reach the pad.
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) begin cfg_drv = 4'hA; cfg_pull = 2'b11; end
            mid();
            checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt[%0d] got %b want 01", k, gnt); end
            checks++; if (pad_oe_n !== 1'b0) begin errors++; $display("FAIL wr_oe[%0d] got %b want 0", k, pad_oe_n); end
            checks++; if (pad_data !== 1'b1) begin errors++; $display("FAIL wr_data[%0d] got %b want 1", k, pad_data); end
            checks++; if ({pad_drv, pad_pu, pad_pd} !== 6'b0101_10) begin errors++; $display("FAIL wr_cfg_hold[%0d] got %b want 010110", k, {pad_drv, pad_pu, pad_pd}); end
        end
        // Request drops: still ACTIVE this cycle, no grant.
        step(); req = 2'b00;
        mid();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL wr_exit_gnt got %b want 00", gnt); end
        for (int k = 0; k < 2; k++) begin
            step(); mid();
            checks++; if ({gnt, pad_oe_n, pad_data} !== 4'b0010) begin errors++; $display("FAIL wr_turn[%0d] gnt/oe/data got %b want 0010", k, {gnt, pad_oe_n, pad_data}); end
        end
        step(); mid();
        checks++; if (pad_drv !== 4'h5) begin errors++; $display("FAIL wr_drv_pre got %h want 5", pad_drv); end
        step(); mid();
        checks++; if ({pad_drv, pad_pu, pad_pd} !== 6'b1010_00) begin errors++; $display("FAIL cfg_load11 got %b want 101000", {pad_drv, pad_pu, pad_pd}); end
    endtask

    task automatic test_read();
        step(); req = 2'b10; we = 2'b00; wdata = 2'b00;
        mid();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rd_idle_gnt got %b want 00", gnt); end
        step(); pad_in = 1'b1;
        mid();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt got %b want 10", gnt); end
        checks++; if (pad_oe_n !== 1'b1) begin errors++; $display("FAIL rd_oe got %b want 1", pad_oe_n); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid got %b want 0", rvalid); end
        step(); req = 2'b00; pad_in = 1'b0;
        mid();
        checks++; if ({rvalid, rdata, rid} !== 3'b111) begin errors++; $display("FAIL rd_resp got %b want 111", {rvalid, rdata, rid}); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rd_exit_gnt got %b want 00", gnt); end
        step(); mid();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got %b want 0", rvalid); end
    endtask

    task automatic test_burst();
        logic [1:0] exp_g [15];
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
                  2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 0) begin req = 2'b11; we = 2'b00; pad_in = 1'b1; end
            mid();
            checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL burst_gnt[%0d] got %b want %b", i, gnt, exp_g[i]); end
            checks++; if (rvalid !== (i > 0 && exp_g[(i > 0) ? i - 1 : 0] != 2'b00)) begin errors++; $display("FAIL burst_rvalid[%0d] got %b", i, rvalid); end
        end
    endtask

    task automatic test_single_write();
        logic [1:0] exp_g [9];
        logic       exp_oe [9];
        exp_g  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        exp_oe = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) begin req = 2'b01; we = 2'b01; wdata = 2'b01; pad_in = 1'b0; end
            mid();
            checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL single_gnt[%0d] got %b want %b", i, gnt, exp_g[i]); end
            checks++; if (pad_oe_n !== exp_oe[i]) begin errors++; $display("FAIL single_oe[%0d] got %b want %b", i, pad_oe_n, exp_oe[i]); end
        end
        step(); req = 2'b00;
    endtask

    task automatic test_flip();
        do_reset();
        step(); req = 2'b11; we = 2'b01; wdata = 2'b01;
        mid();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL flip_idle got %b want 00", gnt); end
        step(); mid();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL flip_gnt0 got %b want 01", gnt); end
        step(); we = 2'b00;
        mid();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL flip_drop got %b want 00", gnt); end
        for (int k = 0; k < 3; k++) begin
            step(); mid();
            checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL flip_gap[%0d] got %b want 00", k, gnt); end
        end
        step(); mid();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL flip_regrant got %b want 10", gnt); end
        step(); req = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(); req = 2'b01; we = 2'b01; wdata = 2'b01;
        mid();
        step(); mid();
        checks++; if ({gnt, pad_oe_n, pad_data} !== 4'b0101) begin errors++; $display("FAIL rmid_drive got %b want 0101", {gnt, pad_oe_n, pad_data}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({gnt, pad_oe_n, pad_data} !== 4'b0010) begin errors++; $display("FAIL rmid_release got %b want 0010", {gnt, pad_oe_n, pad_data}); end
        step(); rst_n = 1'b1; req = 2'b11; we = 2'b11;
        mid();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rmid_idle got %b want 00", gnt); end
        step(); mid();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmid_first got %b want 01", gnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_single_write();
        test_flip();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tc_io_pad_arbiter.md
TC_IO_PAD_ARBITER -- requirements
Module: tc_io_pad_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one bidirectional pad (range 2..8).
REQ-002 SHALL have parameter TurnCycles, default 2, released-pad cycles after a drive phase (range 1..15).
REQ-003 SHALL have parameter MaxBurst, default 16, maximum consecutive transfers per ownership (range 1..255).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  input  NumReq  per-requester transfer request.
REQ-007 SHALL have port we_i  input  NumReq  per-requester direction; 1 = drive pad, 0 = sample pad.
REQ-008 SHALL have port wdata_i  input  NumReq  per-requester bit to drive.
REQ-009 SHALL have port gnt_o  output  NumReq  one-hot transfer grant.
REQ-010 SHALL have port rdata_o  output  1  sampled pad value.
REQ-011 SHALL have port rvalid_o  output  1  rdata_o valid strobe.
REQ-012 SHALL have port rid_o  output  $clog2(NumReq)  requester index of rdata_o.
REQ-013 SHALL have port cfg_drv_i  input  4  requested drive strength.
REQ-014 SHALL have port cfg_pull_i  input  2  bit0 pull-up, bit1 pull-down request.
REQ-015 SHALL have port pad_data_o  output  1  to IO cell data input.
REQ-016 SHALL have port pad_data_i  input  1  from IO cell data output.
REQ-017 SHALL have port pad_oe_no  output  1  IO cell output enable, active-low.
REQ-018 SHALL have ports pad_drv_o (output, 4), pad_pu_o (output, 1), pad_pd_o (output, 1)  registered IO cell strength/pull controls.

Function
REQ-019 SHALL implement FSM states IDLE, ACTIVE, TURN.
REQ-020 IDLE: SHALL select winner W = first requester with req_i high, searching round-robin from index (last owner + 1) mod NumReq; SHALL latch owner=W, dir=we_i[W], clear burst counter, enter ACTIVE next cycle; no grant in IDLE.
REQ-021 ACTIVE: gnt_o[owner] SHALL equal req_i[owner] AND (we_i[owner]==dir), combinationally; all other gnt_o bits 0.
REQ-022 Each cycle with gnt_o[owner] high SHALL be one transfer and SHALL increment the burst counter.
REQ-023 ACTIVE exit: on req_i[owner] low, on we_i[owner]!=dir, or on the transfer that brings the burst count to MaxBurst; exit to TURN if dir=1, else to IDLE.
REQ-024 TURN: SHALL hold exactly TurnCycles cycles, then enter IDLE; no grants.
REQ-025 pad_oe_no SHALL be 0 only in ACTIVE with dir=1, otherwise 1.
REQ-026 pad_data_o SHALL be wdata_i[owner] in ACTIVE with dir=1, otherwise 0.
REQ-027 Read transfer in cycle t: pad_data_i SHALL be sampled at the end of t; rdata_o, rid_o=owner and rvalid_o=1 SHALL appear in cycle t+1 for one cycle.
REQ-028 Last-owner pointer SHALL update on ACTIVE exit, so a still-requesting owner loses priority to any other requester.
REQ-029 pad_drv_o, pad_pu_o, pad_pd_o SHALL load from cfg inputs only in IDLE; cfg_pull_i=2'b11 SHALL load pu=0, pd=0.
REQ-030 A single requester SHALL be re-granted after at most one IDLE cycle (plus TURN if dir=1).

Reset
REQ-031 Asserting rst_ni low SHALL immediately force: state IDLE, gnt_o=0, pad_oe_no=1, pad_data_o=0, rvalid_o=0, rdata_o=0, rid_o=0, pad_drv_o=0, pad_pu_o=0, pad_pd_o=0, last owner=NumReq-1, counters 0.
REQ-032 Reset mid-drive SHALL release the pad (pad_oe_no=1) asynchronously, without a TURN phase.

Verification
REQ-033 Req0 write, wdata 1, held 3 cycles: IDLE 1 cycle, gnt_o=01 and pad_oe_no=0, pad_data_o=1 for 3 cycles, then TURN 2 cycles with pad_oe_no=1.
REQ-034 Req1 read, pad_data_i=1 in cycle t: rvalid_o=1, rdata_o=1, rid_o=1 in cycle t+1 only.
REQ-035 Both requesters continuous, MaxBurst=4: grants alternate in bursts of 4, req0 first after reset, each burst separated by IDLE (plus TURN after writes).
REQ-036 Owner flips we_i mid-burst: gnt_o drops the same cycle, FSM exits ACTIVE, ownership re-arbitrated.
REQ-037 rst_ni low during write: pad_oe_no=1 and gnt_o=0 before the next clock edge; after release first grant goes to req0.
REQ-038 cfg_pull_i=2'b11 loaded in IDLE: pad_pu_o=0, pad_pd_o=0; cfg change during ACTIVE does not alter pad outputs until next IDLE.
